// File: rtl/phy_dly_pkg.sv
// Shared definitions for the IOD delay-lane controller: command opcodes,
// controller state encoding and a lane-index width helper.
package phy_dly_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_SET  = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_MOVE,
    S_SETTLE,
    S_FIN
  } state_t;

  // A single-lane build still needs a 1-bit lane field.
  function automatic int unsigned lane_w(input int unsigned num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage

// File: rtl/phy_dly_lane_ctrl_if.sv
// Command/completion bus of the delay-lane controller.
interface phy_dly_lane_ctrl_if #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned TAP_W     = 8
);
  localparam int unsigned LANE_W = phy_dly_pkg::lane_w(NUM_LANES);

  logic              CMD_VALID;
  logic              CMD_READY;
  logic [1:0]        CMD_OP;
  logic [LANE_W-1:0] CMD_LANE;
  logic [TAP_W-1:0]  CMD_VAL;
  logic              DONE;
  logic              ERR;

  modport master (
    output CMD_VALID, CMD_OP, CMD_LANE, CMD_VAL,
    input  CMD_READY, DONE, ERR
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_LANE, CMD_VAL,
    output CMD_READY, DONE, ERR
  );
endinterface

// File: rtl/phy_dly_settle_cnt.sv
// Loadable down-counter timing the idle gap after each delay-line pulse.
// Loaded the cycle before SETTLE starts; expired is high in the last SETTLE cycle.
module phy_dly_settle_cnt #(
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);
  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Count down from SETTLE_CYC-1 to zero and hold there.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/phy_dly_lane_ctrl.sv
// Per-lane IOD delay-tap controller: executes LOAD/INC/DEC/SET commands as
// registered load/step pulses on one lane and tracks each lane's tap count.
module phy_dly_lane_ctrl
  import phy_dly_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned TAP_W      = 8,
  parameter int unsigned MAX_TAP    = 127,
  parameter int unsigned INIT_TAP   = 1,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                       FAB_CLK,
  input  logic                       ARST_N,
  phy_dly_lane_ctrl_if.slave         bus,
  output logic [NUM_LANES*TAP_W-1:0] TAP_OUT,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE
);
  localparam int unsigned LANE_W = lane_w(NUM_LANES);
  localparam logic [TAP_W-1:0] MAX_T  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] INIT_T = TAP_W'(INIT_TAP);

  state_t            state, state_nxt;
  cmd_op_t           op_q, cmd_op;
  logic [LANE_W-1:0] lane_q, lane_sel;
  logic [TAP_W-1:0]  val_q, tap_sel;
  logic              dir_q, dir_nxt, err_nxt, lane_bad;
  logic              tap_load, tap_step, settle_load, settle_expired;
  logic [NUM_LANES-1:0] lane_mask;
  logic [TAP_W-1:0]  tap [NUM_LANES];

  // In IDLE the lane comes straight from the bus; afterwards from the captured command.
  assign cmd_op    = cmd_op_t'(bus.CMD_OP);
  assign lane_sel  = (state == S_IDLE) ? bus.CMD_LANE : lane_q;
  assign lane_bad  = (32'(bus.CMD_LANE) >= NUM_LANES);
  assign tap_sel   = lane_bad && (state == S_IDLE) ? '0 : tap[lane_sel];
  assign lane_mask = NUM_LANES'(1) << lane_sel;

  phy_dly_settle_cnt #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk     (FAB_CLK),
    .rst_n   (ARST_N),
    .load    (settle_load),
    .expired (settle_expired)
  );

  // Next-state, step direction, error and tap-update decisions.
  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir_q;
    err_nxt     = 1'b0;
    tap_load    = 1'b0;
    tap_step    = 1'b0;
    settle_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.CMD_VALID) begin
          if (lane_bad) begin
            state_nxt = S_FIN;
            err_nxt   = 1'b1;
          end else begin
            case (cmd_op)
              OP_LOAD: begin
                state_nxt = S_LOAD;
                tap_load  = 1'b1;
              end
              OP_INC: begin
                if (tap_sel >= MAX_T) begin
                  state_nxt = S_FIN;
                  err_nxt   = 1'b1;
                end else begin
                  state_nxt = S_SETUP;
                  dir_nxt   = 1'b1;
                end
              end
              OP_DEC: begin
                if (tap_sel == '0) begin
                  state_nxt = S_FIN;
                  err_nxt   = 1'b1;
                end else begin
                  state_nxt = S_SETUP;
                  dir_nxt   = 1'b0;
                end
              end
              OP_SET: begin
                if (bus.CMD_VAL > MAX_T) begin
                  state_nxt = S_FIN;
                  err_nxt   = 1'b1;
                end else if (bus.CMD_VAL == tap_sel) begin
                  state_nxt = S_FIN;
                end else begin
                  state_nxt = S_SETUP;
                  dir_nxt   = (bus.CMD_VAL > tap_sel);
                end
              end
            endcase
          end
        end
      end
      S_LOAD: begin
        state_nxt   = S_SETTLE;
        settle_load = 1'b1;
      end
      S_SETUP: begin
        state_nxt = S_MOVE;
        tap_step  = 1'b1;
      end
      S_MOVE: begin
        state_nxt   = S_SETTLE;
        settle_load = 1'b1;
      end
      S_SETTLE: begin
        if (settle_expired) begin
          if (DELAY_LINE_OUT_OF_RANGE[lane_q]) begin
            state_nxt = S_FIN;
            err_nxt   = 1'b1;
          end else if ((op_q == OP_SET) && (tap_sel != val_q)) begin
            state_nxt = S_SETUP;
            dir_nxt   = (val_q > tap_sel);
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus command capture on acceptance.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state  <= S_IDLE;
      op_q   <= OP_LOAD;
      lane_q <= '0;
      val_q  <= '0;
      dir_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      dir_q <= dir_nxt;
      if ((state == S_IDLE) && bus.CMD_VALID) begin
        op_q   <= cmd_op;
        lane_q <= bus.CMD_LANE;
        val_q  <= bus.CMD_VAL;
      end
    end
  end

  // Tracked tap per lane: set on LOAD entry, stepped on MOVE entry.
  // NOTE: the tap array is a handful of flops, so it is reset like any other register.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      for (int i = 0; i < NUM_LANES; i++) tap[i] <= INIT_T;
    end else if (tap_load) begin
      tap[lane_sel] <= INIT_T;
    end else if (tap_step) begin
      tap[lane_q] <= dir_q ? tap[lane_q] + 1'b1 : tap[lane_q] - 1'b1;
    end
  end

  // Outputs are registered from the next state so each pulse aligns with its state.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      bus.CMD_READY        <= 1'b1;
      bus.DONE             <= 1'b0;
      bus.ERR              <= 1'b0;
      DELAY_LINE_MOVE      <= '0;
      DELAY_LINE_DIRECTION <= '0;
      DELAY_LINE_LOAD      <= '0;
    end else begin
      bus.CMD_READY        <= (state_nxt == S_IDLE);
      bus.DONE             <= (state_nxt == S_FIN);
      bus.ERR              <= err_nxt;
      DELAY_LINE_MOVE      <= (state_nxt == S_MOVE) ? lane_mask : '0;
      DELAY_LINE_DIRECTION <= (((state_nxt == S_SETUP) || (state_nxt == S_MOVE)) && dir_nxt)
                              ? lane_mask : '0;
      DELAY_LINE_LOAD      <= (state_nxt == S_LOAD) ? lane_mask : '0;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_tap_out
    assign TAP_OUT[i*TAP_W +: TAP_W] = tap[i];
  end
endmodule

// File: tb/tb_phy_dly_lane_ctrl.sv
// Scoreboard bench for phy_dly_lane_ctrl: the driver pushes the expected
// completion of each command, an independent monitor checks pulses and DONE.
module tb_phy_dly_lane_ctrl;
  import phy_dly_pkg::*;

  localparam int NL = 2, TW = 8, MAX_TAP = 127, INIT_TAP = 1, S = 4;

  typedef struct {
    int             lat;
    logic           err;
    logic [NL*TW-1:0] taps;
    int             moves;
    int             loads;
    int             lane;
    logic           dir;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NL*TW-1:0] tap_out;
  logic [NL-1:0] dl_move, dl_dir, dl_load;
  logic [NL-1:0] dl_oor = '0;

  phy_dly_lane_ctrl_if #(.NUM_LANES(NL), .TAP_W(TW)) bus ();

  phy_dly_lane_ctrl #(
    .NUM_LANES(NL), .TAP_W(TW), .MAX_TAP(MAX_TAP), .INIT_TAP(INIT_TAP), .SETTLE_CYC(S)
  ) dut (
    .FAB_CLK                 (clk),
    .ARST_N                  (rst_n),
    .bus                     (bus.slave),
    .TAP_OUT                 (tap_out),
    .DELAY_LINE_MOVE         (dl_move),
    .DELAY_LINE_DIRECTION    (dl_dir),
    .DELAY_LINE_LOAD         (dl_load),
    .DELAY_LINE_OUT_OF_RANGE (dl_oor)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   acc_cyc = 0;
  int   m_tap [NL];
  exp_t sb_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NL*TW-1:0] pack_taps();
    logic [NL*TW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*TW +: TW] = TW'(m_tap[i]);
    return v;
  endfunction

  // Reference model: outcome of one command from the documented rules.
  task automatic model(input logic [1:0] op, input int lane, input int val,
                       input int abort_k, output exp_t e);
    int cur, n;
    cur = m_tap[lane];
    e.lane = lane; e.err = 1'b0; e.moves = 0; e.loads = 0; e.dir = 1'b0; e.lat = 1;
    case (op)
      2'b00: begin m_tap[lane] = INIT_TAP; e.loads = 1; e.lat = 2 + S; end
      2'b01: if (cur >= MAX_TAP) e.err = 1'b1;
             else begin m_tap[lane] = cur + 1; e.moves = 1; e.dir = 1'b1; e.lat = 3 + S; end
      2'b10: if (cur == 0) e.err = 1'b1;
             else begin m_tap[lane] = cur - 1; e.moves = 1; e.lat = 3 + S; end
      default: begin
        if (val > MAX_TAP) e.err = 1'b1;
        else begin
          n = (val > cur) ? val - cur : cur - val;
          e.dir = (val > cur);
          if (abort_k > 0 && abort_k <= n) begin n = abort_k; e.err = 1'b1; end
          m_tap[lane] = e.dir ? cur + n : cur - n;
          e.moves = n;
          e.lat = 1 + n * (2 + S);
        end
      end
    endcase
    e.taps = pack_taps();
  endtask

  initial forever @(posedge clk) cyc++;

  // Monitor: tracks the accepted command, checks each pulse, pops on DONE.
  initial begin
    exp_t cur;
    bit busy = 0;
    int n_moves = 0, n_loads = 0;
    logic [NL-1:0] mask;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0;
      end else begin
        if (bus.CMD_VALID && bus.CMD_READY) begin
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_accept at cycle %0d", cyc);
          end else begin
            cur = sb_q[0]; busy = 1; acc_cyc = cyc; n_moves = 0; n_loads = 0;
          end
        end
        mask = NL'(1) << cur.lane;
        if ((dl_move | dl_load) != '0) begin
          check("move_load_excl", 64'(dl_move & dl_load), 0);
          if (!busy) begin
            errors++;
            $display("FAIL stray_pulse move=%0h load=%0h cycle %0d", dl_move, dl_load, cyc);
          end
        end
        if (busy && dl_move != '0) begin
          check("move_lane", 64'(dl_move), 64'(mask));
          check("move_dir", 64'(dl_dir), cur.dir ? 64'(mask) : 0);
          check("move_time", 64'(cyc - acc_cyc), 64'(2 + n_moves * (2 + S)));
          n_moves++;
        end
        if (busy && dl_load != '0) begin
          check("load_lane", 64'(dl_load), 64'(mask));
          check("load_time", 64'(cyc - acc_cyc), 1);
          n_loads++;
        end
        if (bus.DONE) begin
          if (!busy || sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done at cycle %0d", cyc);
          end else begin
            cur = sb_q.pop_front();
            check("done_latency", 64'(cyc - acc_cyc), 64'(cur.lat));
            check("done_err", 64'(bus.ERR), 64'(cur.err));
            check("tap_out", 64'(tap_out), 64'(cur.taps));
            check("move_count", 64'(n_moves), 64'(cur.moves));
            check("load_count", 64'(n_loads), 64'(cur.loads));
            check("dir_idle_at_done", 64'(dl_dir), 0);
            check("ready_low_at_done", 64'(bus.CMD_READY), 0);
            busy = 0;
            done_cnt++;
          end
        end
      end
    end
  end

  // Driver: issue one command and wait (bounded) for its completion.
  task automatic issue(input logic [1:0] op, input int lane, input int val, input int abort_k);
    exp_t e;
    int n, base;
    model(op, lane, val, abort_k, e);
    sb_q.push_back(e);
    base = done_cnt;
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b1; bus.CMD_OP = op; bus.CMD_LANE = 1'(lane); bus.CMD_VAL = TW'(val);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.CMD_READY && n < 50);
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP = 2'($urandom); bus.CMD_LANE = 1'($urandom); bus.CMD_VAL = TW'($urandom);
    if (abort_k > 0) begin
      repeat (2 + (abort_k - 1) * (2 + S)) @(posedge clk);
      #1 dl_oor[lane] = 1'b1;
    end
    n = 0;
    while (done_cnt == base && n < 3000) begin @(negedge clk); #1; n++; end
    check("done_seen", 64'(done_cnt - base), 1);
    if (done_cnt == base) sb_q.delete();
    dl_oor = '0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  initial begin
    exp_t e;
    int n, rel_cyc, lane, val;
    for (int i = 0; i < NL; i++) m_tap[i] = INIT_TAP;
    bus.CMD_VALID = 1'b0; bus.CMD_OP = '0; bus.CMD_LANE = '0; bus.CMD_VAL = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_ready", 64'(bus.CMD_READY), 1);
    check("rst_done", 64'(bus.DONE), 0);
    check("rst_err", 64'(bus.ERR), 0);
    check("rst_move", 64'(dl_move), 0);
    check("rst_dir", 64'(dl_dir), 0);
    check("rst_load", 64'(dl_load), 0);
    check("rst_taps", 64'(tap_out), 64'(pack_taps()));

    issue(OP_LOAD, 1, 0, 0);       // LOAD lane 1
    issue(OP_SET, 0, 4, 0);        // three up-steps
    issue(OP_SET, 0, 127, 0);      // to the top
    issue(OP_INC, 0, 0, 0);        // INC at MAX_TAP rejected
    issue(OP_SET, 0, 1, 0);
    issue(OP_DEC, 0, 0, 0);        // down to 0
    issue(OP_DEC, 0, 0, 0);        // DEC at 0 rejected
    issue(OP_SET, 0, 200, 0);      // target above MAX_TAP rejected
    issue(OP_SET, 0, 0, 0);        // already there: zero steps
    issue(OP_SET, 1, 10, 2);       // out-of-range after second step

    for (int k = 0; k < 40; k++) begin
      lane = $urandom_range(0, NL - 1);
      val  = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 140) : $urandom_range(0, 30);
      issue(2'($urandom_range(0, 3)), lane, val, 0);
    end

    // Reset in the middle of an INC's settle window, CMD_VALID kept high.
    issue(OP_LOAD, 0, 0, 0);
    model(OP_INC, 0, 0, 0, e);
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.CMD_VALID = 1'b1; bus.CMD_OP = OP_INC; bus.CMD_LANE = 1'b0; bus.CMD_VAL = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.CMD_READY && n < 50);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NL; i++) m_tap[i] = INIT_TAP;
    sb_q.delete();
    check("arst_move", 64'(dl_move), 0);
    check("arst_dir", 64'(dl_dir), 0);
    check("arst_load", 64'(dl_load), 0);
    check("arst_done", 64'(bus.DONE), 0);
    check("arst_err", 64'(bus.ERR), 0);
    check("arst_taps", 64'(tap_out), 64'(pack_taps()));
    model(OP_INC, 0, 0, 0, e);
    sb_q.push_back(e);
    n = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rel_cyc = cyc;
    check("ready_after_release", 64'(bus.CMD_READY), 1);
    @(posedge clk); #1 bus.CMD_VALID = 1'b0;
    repeat (3 + S + 2) @(negedge clk);
    check("post_reset_done", 64'(done_cnt - n), 1);
    check("accept_after_release", 64'(acc_cyc - rel_cyc), 0);
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phy_dly_lane_ctrl.md
PHY_DLY_LANE_CTRL -- requirements
Module: phy_dly_lane_ctrl

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2: number of IOD lanes controlled.
REQ-002 SHALL have parameter TAP_W, default 8: tap counter width.
REQ-003 SHALL have parameter MAX_TAP, default 127: highest legal tap; constraint MAX_TAP < 2**TAP_W.
REQ-004 SHALL have parameter INIT_TAP, default 1: tap value after LOAD and after reset.
REQ-005 SHALL have parameter SETTLE_CYC, default 4, minimum 1: idle cycles after each delay-line pulse.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, as follows.
REQ-007 Port FAB_CLK  in  1: sole clock; all logic rising-edge.
REQ-008 Port ARST_N  in  1: asynchronous active-low reset.
REQ-009 Port CMD_VALID  in  1: command request.
REQ-010 Port CMD_READY  out  1: high only in IDLE.
REQ-011 Port CMD_OP  in  2: 00 LOAD, 01 INC, 10 DEC, 11 SET (absolute).
REQ-012 Port CMD_LANE  in  max(1,$clog2(NUM_LANES)): target lane.
REQ-013 Port CMD_VAL  in  TAP_W: target tap for SET; ignored otherwise.
REQ-014 Port DONE  out  1: one-cycle completion pulse.
REQ-015 Port ERR  out  1: valid with DONE; command rejected or aborted.
REQ-016 Port TAP_OUT  out  NUM_LANES*TAP_W: tracked tap per lane, lane i at bits [i*TAP_W +: TAP_W].
REQ-017 Port DELAY_LINE_MOVE  out  NUM_LANES: per-lane IOD move pulse.
REQ-018 Port DELAY_LINE_DIRECTION  out  NUM_LANES: 1 = increment.
REQ-019 Port DELAY_LINE_LOAD  out  NUM_LANES: per-lane IOD load pulse.
REQ-020 Port DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES: per-lane IOD range flag.

Function
REQ-021 Command accepted on the cycle CMD_VALID && CMD_READY (cycle 0); CMD_LANE/OP/VAL captured then; later changes ignored until DONE.
REQ-022 FSM states: IDLE, LOAD, SETUP, MOVE, SETTLE, FIN.
REQ-023 LOAD op: LOAD state drives DELAY_LINE_LOAD[lane]=1 for exactly cycle 1; tap[lane] := INIT_TAP; SETTLE cycles 2..1+SETTLE_CYC; DONE at cycle 2+SETTLE_CYC.
REQ-024 Step sequence: SETUP drives DIRECTION[lane] for 1 cycle; MOVE drives MOVE[lane]=1 for 1 cycle with DIRECTION held; SETTLE SETTLE_CYC cycles; tap[lane] ±1 on the MOVE cycle.
REQ-025 INC/DEC: one step; DONE at cycle 3+SETTLE_CYC.
REQ-026 SET: repeats steps toward CMD_VAL until tap == CMD_VAL; N steps give DONE at cycle 1+N*(2+SETTLE_CYC); N=0 gives DONE at cycle 1, no pulses.
REQ-027 INC at MAX_TAP, DEC at 0, SET with CMD_VAL > MAX_TAP, or CMD_LANE >= NUM_LANES: no pulses, tap unchanged, DONE+ERR at cycle 1.
REQ-028 DELAY_LINE_OUT_OF_RANGE[lane] sampled high in the last SETTLE cycle: abort remaining steps, DONE+ERR next cycle, tap keeps the value already counted.
REQ-029 FIN lasts 1 cycle (DONE high) then IDLE; CMD_READY low from cycle 1 through the FIN cycle.
REQ-030 Only the addressed lane is driven; all other bits of MOVE/DIRECTION/LOAD stay 0; DIRECTION is 0 outside SETUP/MOVE.
REQ-031 All outputs registered; MOVE and LOAD never high in the same cycle.

Reset
REQ-032 ARST_N low: state IDLE; CMD_READY=1 after release; DONE, ERR, MOVE, DIRECTION, LOAD = 0; every tap = INIT_TAP.
REQ-033 Reset mid-command abandons it with no DONE; software issues LOAD before relying on TAP_OUT.

Structure
REQ-034 Shared package phy_dly_pkg holds the CMD_OP encodings and the FSM state enum.
REQ-035 One sub-module phy_dly_settle_cnt: loadable down-counter producing the SETTLE-expired flag.

Verification (NUM_LANES=2, TAP_W=8, MAX_TAP=127, INIT_TAP=1, SETTLE_CYC=4)
REQ-036 Reset, then LOAD lane 1 -> LOAD[1] high at cycle 1 only, TAP_OUT lane1=1, DONE at cycle 6, ERR=0.
REQ-037 SET lane 0 to 4 from 1 -> 3 MOVE[0] pulses 6 cycles apart with DIRECTION[0]=1, tap0=4, DONE at cycle 19.
REQ-038 SET lane 0 to 127, then INC -> DONE+ERR at cycle 1, no MOVE, tap0=127; then DEC twice from 0 case: second DEC at 0 -> ERR.
REQ-039 SET lane 1 to 10, OUT_OF_RANGE[1] forced high after 2nd MOVE -> tap1=3, DONE+ERR, no 3rd MOVE.
REQ-040 ARST_N asserted during SETTLE of an INC -> outputs 0 immediately, taps=1, no DONE; CMD_VALID held high throughout -> next command accepted in first cycle after release.
